// File: rtl/key_debouncer_pkg.sv
// Shared defaults and helpers for the key debouncer and voice allocator.
package key_pkg;

  localparam int unsigned N_KEYS_DEF = 8;
  localparam int unsigned LIMIT_DEF  = 65535;

  // Widest vector the lowest-set-bit helper can scan.
  localparam int unsigned KEY_MAX    = 64;

  // Index of the lowest set bit of v; 0 when v is all zeros.
  function automatic int unsigned lowest_set(input logic [KEY_MAX-1:0] v);
    int unsigned idx;
    idx = 0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = KEY_MAX - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 32'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// Bundle between the board-pin side and the note/voice control logic.
interface key_debouncer_if
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = N_KEYS_DEF
);

  localparam int unsigned IDX_W = $clog2(N_KEYS);

  logic              tick;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_state;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;
  logic              any_pressed;
  logic [IDX_W-1:0]  key_idx;

  // Side that supplies raw contacts and the sample strobe.
  modport master (
    output tick,
    output key_raw,
    input  key_state,
    input  press_pulse,
    input  release_pulse,
    input  any_pressed,
    input  key_idx
  );

  // The debouncer itself.
  modport slave (
    input  tick,
    input  key_raw,
    output key_state,
    output press_pulse,
    output release_pulse,
    output any_pressed,
    output key_idx
  );

endinterface

// File: rtl/key_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, qualification counter,
// stable level flop and registered press/release pulses.
module debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned LIMIT = LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous contact into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= key_raw;
      sync_q <= meta_q;
    end
  end

  // Qualify a level change over LIMIT uninterrupted tick-high cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (sync_q == key_state) begin
        // Any return to the stable level restarts qualification.
        cnt_q <= '0;
      end else if (tick) begin
        if (cnt_q == CNT_LAST) begin
          key_state     <= sync_q;
          cnt_q         <= '0;
          press_pulse   <= sync_q;
          release_pulse <= ~sync_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Multi-channel key debouncer with any-pressed flag and lowest-key index.
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS = N_KEYS_DEF,
  parameter int unsigned LIMIT  = LIMIT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  key_debouncer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_KEYS);

  logic [N_KEYS-1:0] key_state_w;
  logic [N_KEYS-1:0] press_w;
  logic [N_KEYS-1:0] release_w;

  // Independent channel per key.
  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
    debounce_channel #(
      .LIMIT (LIMIT)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .tick          (bus.tick),
      .key_raw       (bus.key_raw[g]),
      .key_state     (key_state_w[g]),
      .press_pulse   (press_w[g]),
      .release_pulse (release_w[g])
    );
  end

  // Registered per-channel outputs straight to the bus.
  assign bus.key_state     = key_state_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;

  // Summary outputs are combinational from key_state for zero added latency.
  assign bus.any_pressed = |key_state_w;
  assign bus.key_idx     = IDX_W'(lowest_set(KEY_MAX'(key_state_w)));

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer (N_KEYS=4, LIMIT=4).
module tb_key_debouncer;

  localparam int unsigned N     = 4;
  localparam int unsigned LIMIT = 4;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  key_debouncer_if #(.N_KEYS(N)) bus ();

  key_debouncer #(
    .N_KEYS (N),
    .LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sync stream is key_raw delayed two clocks; a channel
  // accepts the new level once LIMIT tick-high cycles of mismatch accumulate
  // without the sync level ever returning to the accepted level.
  logic [N-1:0] pipe [2];
  logic [N-1:0] m_st;
  logic [N-1:0] m_pr;
  logic [N-1:0] m_rl;
  int           run [N];

  task automatic model_reset();
    pipe[0] = '0;
    pipe[1] = '0;
    m_st    = '0;
    m_pr    = '0;
    m_rl    = '0;
    for (int i = 0; i < int'(N); i++) run[i] = 0;
  endtask

  task automatic model_clock();
    logic [N-1:0] s;
    if (!rst_n) begin
      model_reset();
    end else begin
      s    = pipe[1];
      m_pr = '0;
      m_rl = '0;
      for (int i = 0; i < int'(N); i++) begin
        if (s[i] == m_st[i]) begin
          run[i] = 0;
        end else begin
          run[i] = run[i] + (bus.tick ? 1 : 0);
          if (run[i] >= int'(LIMIT)) begin
            m_st[i] = s[i];
            if (s[i]) m_pr[i] = 1'b1;
            else      m_rl[i] = 1'b1;
            run[i] = 0;
          end
        end
      end
      pipe[1] = pipe[0];
      pipe[0] = bus.key_raw;
    end
  endtask

  function automatic int exp_idx(input logic [N-1:0] s);
    int r;
    r = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (s[i]) begin
        r = i;
        break;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".key_state"}, 32'(bus.key_state), 32'(m_st));
    chk({tag, ".press"},     32'(bus.press_pulse), 32'(m_pr));
    chk({tag, ".release"},   32'(bus.release_pulse), 32'(m_rl));
    chk({tag, ".any"},       32'(bus.any_pressed), 32'(|m_st));
    chk({tag, ".idx"},       32'(bus.key_idx), 32'(exp_idx(m_st)));
  endtask

  // Advance one clock: model follows the edge, outputs checked on negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int lat;
    int npress;
    logic [N-1:0] seen_pr;
    logic [N-1:0] seen_rl;
    logic [N-1:0] r;

    checks      = 0;
    errors      = 0;
    rst_n       = 1'b1;
    bus.tick    = 1'b0;
    bus.key_raw = '0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    compare_all("por");
    @(negedge clk);
    rst_n    = 1'b1;
    bus.tick = 1'b1;

    // Hold all keys until accepted, then reset mid-run.
    bus.key_raw = 4'b1111;
    for (int k = 0; k < 8; k++) step("hold_all");
    chk("hold_all_state", 32'(bus.key_state), 32'hf);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async_rst");
    chk("async_rst_any", 32'(bus.any_pressed), 32'h0);

    // Release reset with key 1 held: press reported after normal qualification.
    @(negedge clk);
    bus.key_raw = 4'b0010;
    rst_n       = 1'b1;
    lat         = -1;
    npress      = 0;
    for (int k = 1; k <= 12; k++) begin
      step("rst_rel");
      if (bus.press_pulse[1]) begin
        npress++;
        if (lat < 0) lat = k;
      end
    end
    chk("rst_rel_latency", 32'(lat), 32'd6);
    chk("rst_rel_npress", 32'(npress), 32'd1);

    // Clean press of key 0 from idle.
    bus.key_raw = '0;
    for (int k = 0; k < 10; k++) step("idle0");
    bus.key_raw = 4'b0001;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      step("clean_press");
      if (lat < 0 && bus.press_pulse != '0) begin
        lat = k;
        chk("clean_press_pulse", 32'(bus.press_pulse), 32'h1);
      end
    end
    chk("clean_press_latency", 32'(lat), 32'd6);
    chk("clean_press_any", 32'(bus.any_pressed), 32'h1);
    chk("clean_press_idx", 32'(bus.key_idx), 32'h0);

    // Bounce on key 2: high 3, low 1, then steady.
    npress = 0;
    lat    = -1;
    bus.key_raw[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("bounce_hi");
      if (bus.press_pulse[2]) npress++;
    end
    bus.key_raw[2] = 1'b0;
    step("bounce_lo");
    if (bus.press_pulse[2]) npress++;
    bus.key_raw[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step("bounce_steady");
      if (bus.press_pulse[2]) begin
        npress++;
        if (lat < 0) lat = k;
      end
    end
    chk("bounce_npress", 32'(npress), 32'd1);
    chk("bounce_latency", 32'(lat), 32'd6);

    // Sparse tick: one tick-high cycle in three, key 3 held.
    bus.key_raw[3] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      bus.tick = (k % 3 == 0);
      step("tick_gate");
      if (lat < 0 && bus.press_pulse[3]) lat = k;
    end
    // Sync mismatch from step 2; ticks at 3,6,9,12 -> accepted on step 12.
    chk("tick_gate_latency", 32'(lat), 32'd12);
    bus.tick = 1'b1;

    // Simultaneous press of keys 1 and 3 from idle.
    bus.key_raw = '0;
    for (int k = 0; k < 10; k++) step("idle1");
    bus.key_raw = 4'b1010;
    seen_pr = '0;
    for (int k = 0; k < 10; k++) begin
      step("simul_press");
      if (bus.press_pulse != '0 && seen_pr == '0) seen_pr = bus.press_pulse;
    end
    chk("simul_press_pulse", 32'(seen_pr), 32'ha);
    chk("simul_press_idx", 32'(bus.key_idx), 32'h1);
    bus.key_raw = 4'b1000;
    seen_rl = '0;
    for (int k = 0; k < 10; k++) begin
      step("simul_rel");
      if (bus.release_pulse != '0 && seen_rl == '0) seen_rl = bus.release_pulse;
    end
    chk("simul_rel_pulse", 32'(seen_rl), 32'h2);
    chk("simul_rel_idx", 32'(bus.key_idx), 32'h3);

    // Release to idle, then a 3-cycle glitch that must be ignored.
    bus.key_raw = '0;
    for (int k = 0; k < 10; k++) step("idle2");
    chk("idle_any", 32'(bus.any_pressed), 32'h0);
    chk("idle_idx", 32'(bus.key_idx), 32'h0);
    npress = 0;
    bus.key_raw = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step("glitch");
      if (bus.press_pulse != '0) npress++;
    end
    bus.key_raw = '0;
    for (int k = 0; k < 10; k++) begin
      step("glitch_after");
      if (bus.press_pulse != '0) npress++;
    end
    chk("glitch_npress", 32'(npress), 32'd0);

    // Randomised contacts and tick against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = bus.key_raw;
        r[$urandom_range(0, N - 1)] ^= 1'b1;
        bus.key_raw = r;
      end
      bus.tick = ($urandom_range(0, 3) != 0);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Parametrised multi-channel debouncer for the synthesizer's key/button inputs. Each channel synchronises a raw asynchronous contact and qualifies a level change only after it persists for a programmable number of sample ticks. It then reports the stable level, one-cycle press/release pulses, and a priority-encoded "lowest pressed key" index. It sits between the board pins and the note/voice control logic, and replaces single-channel fixed-width debounce counters.

## Interface

- N_KEYS, 8: number of independent channels; must be ≥ 2.
- LIMIT, 65535: consecutive qualifying ticks required to accept a change; must be ≥ 1.
- CNT_W (localparam), $clog2(LIMIT+1): per-channel counter width.
- IDX_W (localparam), $clog2(N_KEYS): width of key_idx.

Ports:

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  sample strobe; counters advance only when high. Tie to 1 for per-clk counting.
- key_raw  in  N_KEYS  raw contacts, active-high (1 = pressed), asynchronous to clk.
- key_state  out  N_KEYS  debounced level per channel.
- press_pulse  out  N_KEYS  one-cycle pulse when a channel's key_state goes 0→1.
- release_pulse  out  N_KEYS  one-cycle pulse when a channel's key_state goes 1→0.
- any_pressed  out  1  OR of key_state.
- key_idx  out  IDX_W  lowest index i with key_state[i]=1; 0 when none pressed.

## Operation

- Per channel, a 2-flop synchroniser produces sync[i]. All later logic uses sync[i] only.
- Per channel, a CNT_W counter cnt[i] and a stable flop key_state[i].
- Each cycle, per channel:
  - If sync == key_state: cnt ← 0. This happens regardless of tick.
  - If sync != key_state, tick=1 and cnt == LIMIT-1: key_state ← sync, cnt ← 0, and the matching pulse is asserted.
  - If sync != key_state, tick=1 and cnt < LIMIT-1: cnt ← cnt+1.
  - If sync != key_state and tick=0: cnt holds.
- A single bounce back to the stable level restarts qualification from 0.
- Counter never exceeds LIMIT-1. No wrap-around is possible.
- press_pulse/release_pulse are registered. They are high in exactly the cycle key_state first shows the new value, and low otherwise. Press and release pulses are never high together on one channel.
- Channels are fully independent. Any number may change in the same cycle, each producing its own pulse.
- any_pressed and key_idx are combinational from key_state. This gives zero added latency.
- Reset: sync flops, cnt, key_state, press_pulse and release_pulse all go to 0. As a result, any_pressed=0 and key_idx=0. A key held through reset release is reported as a press after normal qualification.

## Timing

- Latency from a clean key_raw edge, with tick tied high: 2 cycles of synchroniser, then LIMIT cycles of counting. key_state and the pulse therefore update on the edge LIMIT+2 clocks after key_raw first samples the new value.
- With a sparse tick, qualification takes LIMIT tick-high cycles while mismatched, plus synchroniser delay. Actual time depends on tick spacing.
- Minimum accepted pulse width is LIMIT qualifying ticks. Shorter glitches produce no output change.
- Reset asserted mid-count: all state clears immediately, without waiting for clk.

## Structure

- Shared package key_pkg holds default N_KEYS and LIMIT.
- Shared package key_pkg also holds the helper function for lowest-set-bit encoding, reused by the voice allocator.
- Sub-module debounce_channel contains one synchroniser, counter, stable flop and pulse flops, parametrised by LIMIT.
- The top generates N_KEYS instances and adds the any_pressed OR and the key_idx priority encoder.

## Test plan

Bench parameters: N_KEYS=4, LIMIT=4.

- Reset: assert rst_n=0 mid-run with keys held → all outputs 0 immediately. Release reset with key_raw=4'b0010 and tick=1 → key_state[1]=1 and press_pulse[1] high for one cycle, 6 clocks after reset release.
- Clean press: key_raw[0] 0→1 with tick=1 → key_state=4'b0001, press_pulse=4'b0001 for exactly 1 cycle at +6 clocks. Then any_pressed=1 and key_idx=0.
- Bounce: key_raw[2] toggles high 3 cycles, low 1 cycle, then high steadily → no output until 4 uninterrupted qualifying cycles after the last rise. Exactly one press_pulse[2].
- Tick gating: tick high 1 of every 3 cycles, key_raw[3] held high → key_state[3] rises after the 4th tick-high cycle post-synchroniser. A mismatch persisting over tick=0 gaps neither clears nor advances cnt.
- Simultaneous activity: keys 1 and 3 pressed in the same cycle → both pulses in the same cycle and key_idx=1. Key 1 then released → release_pulse=4'b0010 and key_idx=3.
- Release-to-idle: all keys released → release pulses, any_pressed=0, key_idx=0. A 3-cycle glitch afterwards produces no pulse.
